// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent TX serialiser and RX deserialiser sharing one clock.
// Define UART_FRAME_ERR_EN to add o_rx_frame_err (stop-bit errors and start-bit glitches).
module uart_txrx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_byte_rdy,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_busy,
  output logic       o_tx,
  output logic       o_tx_done,
  input  logic       i_rx,
`ifdef UART_FRAME_ERR_EN
  output logic       o_rx_frame_err,
`endif
  output logic       o_rx_byte_rdy,
  output logic [7:0] o_rx_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // ---------------------------------------------------------------- TX
  logic [2:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_q, tx_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (i_tx_byte_rdy) begin
          tx_state_d = S_START;
          tx_data_d  = i_tx_byte;
        end
      end
      S_START: if (tx_bit_end) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
      end
      S_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_idx_d = tx_idx_q + 1'b1;
        if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
      end
      S_STOP: if (tx_bit_end) begin
        tx_state_d = S_DONE;
        tx_cnt_d   = '0;
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered so the serial pin never glitches.
    tx_d      = 1'b1;
    tx_busy_d = 1'b0;
    tx_done_d = 1'b0;
    case (tx_state_d)
      S_START: begin tx_d = 1'b0;                  tx_busy_d = 1'b1; end
      S_DATA:  begin tx_d = tx_data_d[tx_idx_d];   tx_busy_d = 1'b1; end
      S_STOP:  tx_busy_d = 1'b1;
      S_DONE:  tx_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state updates use non-blocking assignments; reset is synchronous, sampled on the clock edge.
    if (i_rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_data_q  <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_data_q  <= tx_data_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = tx_busy_q;
  assign o_tx_done = tx_done_q;

  // ---------------------------------------------------------------- RX
  logic [1:0]    rx_sync_q;
  logic          rx_s;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic          rx_bit_end;
`ifdef UART_FRAME_ERR_EN
  logic          rx_err_q, rx_err_d;
`endif

  assign rx_s       = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_rdy_d   = 1'b0;
`ifdef UART_FRAME_ERR_EN
    rx_err_d   = 1'b0;
`endif
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s) rx_state_d = S_START;
      end
      // Mid-bit recheck of the start bit; a high line here means the low was only a glitch.
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (rx_s) begin
          rx_state_d = S_IDLE;
`ifdef UART_FRAME_ERR_EN
          rx_err_d   = 1'b1;
`endif
        end else begin
          rx_state_d = S_DATA;
        end
      end
      S_DATA: if (rx_bit_end) begin
        rx_cnt_d             = '0;
        rx_shift_d[rx_idx_q] = rx_s;
        rx_idx_d             = rx_idx_q + 1'b1;
        if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
      end
      S_STOP: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_state_d = S_DONE;
        if (rx_s) begin
          rx_byte_d = rx_shift_q;
          rx_rdy_d  = 1'b1;
        end else begin
`ifdef UART_FRAME_ERR_EN
          rx_err_d  = 1'b1;
`endif
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], i_rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

`ifdef UART_FRAME_ERR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) rx_err_q <= 1'b0;
    else       rx_err_q <= rx_err_d;
  end

  assign o_rx_frame_err = rx_err_q;
`endif

  assign o_rx_byte     = rx_byte_q;
  assign o_rx_byte_rdy = rx_rdy_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: directed scenarios plus randomized full-duplex frames.
// Expected TX waveforms and RX bytes come from a frame-level model ({stop, data, start} bit lists, byte queues).
module tb_uart_txrx;

  localparam int CPB = 434;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_tx_byte_rdy;
  logic [7:0] i_tx_byte;
  logic       o_tx_busy;
  logic       o_tx;
  logic       o_tx_done;
  logic       i_rx;
  logic       o_rx_byte_rdy;
  logic [7:0] o_rx_byte;
`ifdef UART_FRAME_ERR_EN
  logic       o_rx_frame_err;
  int         err_cnt = 0;
`endif

  logic       rx_drv  = 1'b1;
  bit         loop_en = 1'b0;
  int         checks  = 0;
  int         passes  = 0;
  logic [7:0] rx_got[$];
  logic [7:0] rx_last_exp;

  assign i_rx = loop_en ? o_tx : rx_drv;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_tx_byte_rdy (i_tx_byte_rdy),
    .i_tx_byte     (i_tx_byte),
    .o_tx_busy     (o_tx_busy),
    .o_tx          (o_tx),
    .o_tx_done     (o_tx_done),
    .i_rx          (i_rx),
`ifdef UART_FRAME_ERR_EN
    .o_rx_frame_err(o_rx_frame_err),
`endif
    .o_rx_byte_rdy (o_rx_byte_rdy),
    .o_rx_byte     (o_rx_byte)
  );

  always #5 i_clk = ~i_clk;

  // Every cycle with rdy high records one received byte, so a stretched pulse shows up as an extra entry.
  always @(negedge i_clk) begin
    if (o_rx_byte_rdy === 1'b1) rx_got.push_back(o_rx_byte);
`ifdef UART_FRAME_ERR_EN
    if (o_rx_frame_err === 1'b1) err_cnt++;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rx_drive(input logic [7:0] b, input int start_len, input logic stop_v, input int stop_len);
    rx_drv = 1'b0;
    repeat (start_len) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) tick();
    end
    rx_drv = stop_v;
    repeat (stop_len) tick();
    rx_drv = 1'b1;
  endtask

  // Issues a request, then checks {busy,tx,done} on every cycle of the 10 bit periods and the done cycle.
  task automatic tx_send_check(input logic [7:0] b, input string name);
    logic [9:0] frame;
    logic [2:0] seen;
    bit         bad;
    frame         = {1'b1, b, 1'b0};
    i_tx_byte     = b;
    i_tx_byte_rdy = 1'b1;
    tick();
    i_tx_byte_rdy = 1'b0;
    i_tx_byte     = ~b;
    for (int n = 0; n < 10; n++) begin
      bad  = 1'b0;
      seen = 3'b000;
      for (int c = 0; c < CPB; c++) begin
        if (!bad && {o_tx_busy, o_tx, o_tx_done} !== {1'b1, frame[n], 1'b0}) begin
          bad  = 1'b1;
          seen = {o_tx_busy, o_tx, o_tx_done};
        end
        if (n < 9 && c == CPB / 2) begin
          i_tx_byte_rdy = 1'($urandom_range(0, 1));
          i_tx_byte     = 8'($urandom);
        end
        if (n == 9) i_tx_byte_rdy = 1'b0;
        tick();
      end
      checks++;
      if (bad) $display("FAIL %s bit%0d: {busy,tx,done}=%b expected %b", name, n, seen, {1'b1, frame[n], 1'b0});
      else passes++;
    end
    checks++;
    if ({o_tx_busy, o_tx, o_tx_done} !== 3'b011)
      $display("FAIL %s done_cycle: {busy,tx,done}=%b expected 011", name, {o_tx_busy, o_tx, o_tx_done});
    else passes++;
  endtask

  task automatic test_reset();
    i_rst         = 1'b1;
    i_tx_byte_rdy = 1'b0;
    i_tx_byte     = 8'h00;
    rx_drv        = 1'b1;
    repeat (3) tick();
    checks++; if (o_tx !== 1'b1)          $display("FAIL reset_tx: got %b expected 1", o_tx); else passes++;
    checks++; if (o_tx_busy !== 1'b0)     $display("FAIL reset_busy: got %b expected 0", o_tx_busy); else passes++;
    checks++; if (o_tx_done !== 1'b0)     $display("FAIL reset_done: got %b expected 0", o_tx_done); else passes++;
    checks++; if (o_rx_byte !== 8'h00)    $display("FAIL reset_rx_byte: got %h expected 00", o_rx_byte); else passes++;
    checks++; if (o_rx_byte_rdy !== 1'b0) $display("FAIL reset_rx_rdy: got %b expected 0", o_rx_byte_rdy); else passes++;
    rx_last_exp = 8'h00;
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_tx_ab();
    tx_send_check(8'hAB, "tx_ab");
    tick();
    checks++;
    if ({o_tx_busy, o_tx, o_tx_done} !== 3'b010)
      $display("FAIL tx_ab_idle: {busy,tx,done}=%b expected 010", {o_tx_busy, o_tx, o_tx_done});
    else passes++;
  endtask

  task automatic test_rx_stretch();
    rx_got.delete();
    rx_drive(8'h3F, CPB + 50, 1'b1, CPB);
    repeat (CPB) tick();
    rx_last_exp = 8'h3F;
    checks++; if (rx_got.size() !== 1) $display("FAIL rx_stretch_pulses: got %0d expected 1", rx_got.size()); else passes++;
    checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL rx_stretch_byte: got %h expected %h", o_rx_byte, rx_last_exp); else passes++;
    repeat (500) tick();
    checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL rx_stretch_hold: got %h expected %h", o_rx_byte, rx_last_exp); else passes++;
  endtask

  task automatic test_rx_glitch();
`ifdef UART_FRAME_ERR_EN
    int err0;
    err0 = err_cnt;
`endif
    rx_got.delete();
    rx_drv = 1'b0;
    repeat (100) tick();
    rx_drv = 1'b1;
    repeat (CPB) tick();
    checks++; if (rx_got.size() !== 0) $display("FAIL glitch_pulses: got %0d expected 0", rx_got.size()); else passes++;
    checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL glitch_byte: got %h expected %h", o_rx_byte, rx_last_exp); else passes++;
`ifdef UART_FRAME_ERR_EN
    checks++; if (err_cnt - err0 !== 1) $display("FAIL glitch_err: got %0d pulses expected 1", err_cnt - err0); else passes++;
`endif
    rx_drive(8'h55, CPB, 1'b1, CPB);
    repeat (4) tick();
    rx_last_exp = 8'h55;
    checks++; if (rx_got.size() !== 1) $display("FAIL after_glitch_pulses: got %0d expected 1", rx_got.size()); else passes++;
    checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL after_glitch_byte: got %h expected %h", o_rx_byte, rx_last_exp); else passes++;
  endtask

  // The stop bit is held low only past its mid-bit sample point; the error window is checked right after it.
  task automatic test_rx_bad_stop();
`ifdef UART_FRAME_ERR_EN
    int err0;
    err0 = err_cnt;
`endif
    rx_got.delete();
    rx_drive(8'hC3, CPB, 1'b0, CPB / 2 + 10);
`ifdef UART_FRAME_ERR_EN
    checks++; if (err_cnt - err0 !== 1) $display("FAIL bad_stop_err: got %0d pulses expected 1", err_cnt - err0); else passes++;
`endif
    repeat (CPB) tick();
    checks++; if (rx_got.size() !== 0) $display("FAIL bad_stop_pulses: got %0d expected 0", rx_got.size()); else passes++;
    checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL bad_stop_byte: got %h expected %h", o_rx_byte, rx_last_exp); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    loop_en = 1'b1;
    rx_got.delete();
    tx_send_check(8'h00, "b2b_first");
    i_tx_byte     = 8'hFF;
    i_tx_byte_rdy = 1'b1;
    tick();
    checks++;
    if ({o_tx_busy, o_tx} !== 2'b01)
      $display("FAIL b2b_done_ignored: {busy,tx}=%b expected 01", {o_tx_busy, o_tx});
    else passes++;
    tx_send_check(8'hFF, "b2b_second");
    repeat (10) tick();
    got = (rx_got.size() == 2) ? {rx_got[0], rx_got[1]} : 16'hxxxx;
    rx_last_exp = 8'hFF;
    checks++; if (rx_got.size() !== 2) $display("FAIL b2b_pulses: got %0d expected 2", rx_got.size()); else passes++;
    checks++; if (got !== 16'h00FF) $display("FAIL b2b_bytes: got %h expected 00ff", got); else passes++;
    checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL b2b_held: got %h expected %h", o_rx_byte, rx_last_exp); else passes++;
    loop_en = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    i_tx_byte     = 8'h5A;
    i_tx_byte_rdy = 1'b1;
    tick();
    i_tx_byte_rdy = 1'b0;
    repeat (1000) tick();
    checks++; if (o_tx_busy !== 1'b1) $display("FAIL midtx_busy: got %b expected 1", o_tx_busy); else passes++;
    i_rst = 1'b1;
    tick();
    rx_last_exp = 8'h00;
    checks++; if (o_tx !== 1'b1)      $display("FAIL midtx_rst_tx: got %b expected 1", o_tx); else passes++;
    checks++; if (o_tx_busy !== 1'b0) $display("FAIL midtx_rst_busy: got %b expected 0", o_tx_busy); else passes++;
    checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL midtx_rst_rx_byte: got %h expected %h", o_rx_byte, rx_last_exp); else passes++;
    i_rst = 1'b0;
    repeat (CPB) tick();
    checks++;
    if ({o_tx_busy, o_tx, o_tx_done} !== 3'b010)
      $display("FAIL midtx_aborted: {busy,tx,done}=%b expected 010", {o_tx_busy, o_tx, o_tx_done});
    else passes++;
  endtask

  task automatic test_random_duplex();
    logic [7:0] tb_byte;
    logic [7:0] rb_byte;
    int         skew;
    for (int it = 0; it < 4; it++) begin
      tb_byte = 8'($urandom);
      rb_byte = 8'($urandom);
      skew    = int'($urandom_range(0, 300)) - 150;
      rx_got.delete();
      fork
        tx_send_check(tb_byte, "dup_tx");
        rx_drive(rb_byte, CPB + skew, 1'b1, CPB);
      join
      repeat (5) tick();
      rx_last_exp = rb_byte;
      checks++; if (rx_got.size() !== 1) $display("FAIL dup_rx_pulses[%0d]: got %0d expected 1", it, rx_got.size()); else passes++;
      checks++; if (o_rx_byte !== rx_last_exp) $display("FAIL dup_rx_byte[%0d]: got %h expected %h (skew %0d)", it, o_rx_byte, rx_last_exp, skew); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_tx_ab();
    test_rx_stretch();
    test_rx_glitch();
    test_rx_bad_stop();
    test_back_to_back();
    test_reset_mid_tx();
    test_random_duplex();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
